// File: rtl/seven_seg_compare_scan_pkg.sv
// Shared segment encodings for the compare/scan display: active-low,
// bit7..bit1 = a..g, bit0 = dp (1 = dark).
package seven_seg_compare_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_U     = 8'b1000_0011;
    localparam logic [7:0] SEG_L     = 8'b1110_0011;

    localparam logic [7:0] SEG_HEX_0 = 8'h03;
    localparam logic [7:0] SEG_HEX_1 = 8'h9F;
    localparam logic [7:0] SEG_HEX_2 = 8'h25;
    localparam logic [7:0] SEG_HEX_3 = 8'h0D;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h49;
    localparam logic [7:0] SEG_HEX_6 = 8'h41;
    localparam logic [7:0] SEG_HEX_7 = 8'h1F;
    localparam logic [7:0] SEG_HEX_8 = 8'h01;
    localparam logic [7:0] SEG_HEX_9 = 8'h09;
    localparam logic [7:0] SEG_HEX_A = 8'h11;
    localparam logic [7:0] SEG_HEX_B = 8'hC1;
    localparam logic [7:0] SEG_HEX_C = 8'h63;
    localparam logic [7:0] SEG_HEX_D = 8'h85;
    localparam logic [7:0] SEG_HEX_E = 8'h61;
    localparam logic [7:0] SEG_HEX_F = 8'h71;

    typedef enum logic {
        MODE_STATUS = 1'b0,
        MODE_HEX    = 1'b1
    } disp_mode_e;

    // Replace the dp bit of a glyph; dp is lit (driven 0) when dp_on = 1.
    function automatic logic [7:0] seg_with_dp(input logic [7:0] glyph, input logic dp_on);
        return {glyph[7:1], ~dp_on};
    endfunction

endpackage

// File: rtl/seven_seg_compare_scan_hex.sv
// Combinational hex nibble to active-low seven-segment glyph (dp dark).
module hex_to_seg
    import seven_seg_compare_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_compare_scan.sv
// Compares two packed-nibble values digit by digit and scans the per-digit
// result (U/L status or hex with mismatch dp) onto a multiplexed display.
module seven_seg_compare_scan
    import seven_seg_compare_scan_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 100000
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_a,
    input  logic [4*DIGITS-1:0]   value_b,
    input  logic                  cmp_valid,
    input  logic                  mode,
    input  logic                  sticky_en,
    input  logic                  clear_sticky,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  match_all,
    output logic                  mismatch_seen
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                samp_valid;

    logic [DIGITS-1:0]   eq_now;
    logic [DIGITS-1:0]   eq_flags;
    logic [DIGITS-1:0]   sticky_flags;
    logic [4*DIGITS-1:0] disp_a;
    logic                valid_seen;

    logic [CNT_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    digit_idx;

    logic [3:0]          cur_nib;
    logic                cur_eq;
    logic                cur_sticky;
    logic                cur_mismatch;
    logic [DIGITS-1:0]   an_next;
    logic [7:0]          hex_glyph;
    logic [7:0]          seg_next;

    // Stage 1: capture the operand pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            samp_valid <= 1'b0;
        end else begin
            samp_valid <= cmp_valid;
            if (cmp_valid) begin
                a_q <= value_a;
                b_q <= value_b;
            end
        end
    end

    always_comb begin
        eq_now = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            eq_now[k] = (a_q[4*k +: 4] == b_q[4*k +: 4]);
        end
    end

    // Stage 2: equal flags, summary and sticky history. A fresh mismatch
    // overrides a coincident clear for the same digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eq_flags     <= '1;
            sticky_flags <= '0;
            disp_a       <= '0;
            valid_seen   <= 1'b0;
            match_all    <= 1'b0;
        end else begin
            sticky_flags <= (sticky_flags & ~{DIGITS{clear_sticky}})
                          | (samp_valid ? ~eq_now : '0);
            if (samp_valid) begin
                eq_flags   <= eq_now;
                disp_a     <= a_q;
                valid_seen <= 1'b1;
                match_all  <= &eq_now;
            end
        end
    end

    assign mismatch_seen = |sticky_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        cur_nib    = '0;
        cur_eq     = 1'b1;
        cur_sticky = 1'b0;
        an_next    = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nib    = disp_a[4*k +: 4];
                cur_eq     = eq_flags[k];
                cur_sticky = sticky_flags[k];
                an_next[k] = 1'b0;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex (cur_nib),
        .seg (hex_glyph)
    );

    always_comb begin
        cur_mismatch = ~cur_eq | (sticky_en & cur_sticky);
        if (!valid_seen) begin
            seg_next = SEG_BLANK;
        end else if (disp_mode_e'(mode) == MODE_STATUS) begin
            seg_next = cur_mismatch ? SEG_L : SEG_U;
        end else begin
            seg_next = seg_with_dp(hex_glyph, cur_mismatch);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out <= SEG_BLANK;
            an_out  <= '1;
        end else begin
            seg_out <= seg_next;
            an_out  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_compare_scan.sv
// Randomized and directed checks of seven_seg_compare_scan (4 digits, refresh 4)
// against a per-digit behavioural model.
module tb_seven_seg_compare_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned W      = 4 * DIGITS;

    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   value_a = '0;
    logic [W-1:0]   value_b = '0;
    logic           cmp_valid = 1'b0;
    logic           mode = 1'b0;
    logic           sticky_en = 1'b0;
    logic           clear_sticky = 1'b0;
    logic [7:0]     seg_out;
    logic [DIGITS-1:0] an_out;
    logic           match_all;
    logic           mismatch_seen;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    bit          m_seen;
    bit          m_match;
    bit          m_eq [DIGITS];
    bit          m_sticky [DIGITS];
    logic [3:0]  m_a [DIGITS];

    logic [7:0]  obs_seg [DIGITS];
    bit          obs_hit [DIGITS];
    int unsigned obs_bad;

    seven_seg_compare_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .value_a       (value_a),
        .value_b       (value_b),
        .cmp_valid     (cmp_valid),
        .mode          (mode),
        .sticky_en     (sticky_en),
        .clear_sticky  (clear_sticky),
        .seg_out       (seg_out),
        .an_out        (an_out),
        .match_all     (match_all),
        .mismatch_seen (mismatch_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    function automatic void model_reset();
        m_seen  = 1'b0;
        m_match = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            m_eq[k]     = 1'b1;
            m_sticky[k] = 1'b0;
            m_a[k]      = 4'h0;
        end
    endfunction

    function automatic void model_compare(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
        m_seen  = 1'b1;
        m_match = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            logic [3:0] na, nb;
            na = a[4*k +: 4];
            nb = b[4*k +: 4];
            m_a[k]  = na;
            m_eq[k] = (na == nb);
            if (clr) m_sticky[k] = 1'b0;
            if (na != nb) begin
                m_sticky[k] = 1'b1;
                m_match     = 1'b0;
            end
        end
    endfunction

    function automatic bit model_mis_seen();
        bit any = 1'b0;
        for (int k = 0; k < DIGITS; k++) any |= m_sticky[k];
        return any;
    endfunction

    function automatic logic [7:0] exp_seg(input int k);
        bit mis;
        logic [7:0] g;
        if (!m_seen) return 8'hFF;
        mis = !m_eq[k] || (sticky_en && m_sticky[k]);
        if (mode == 1'b0) return mis ? 8'b1110_0011 : 8'b1000_0011;
        g = HEX_GLYPH[m_a[k]];
        return {g[7:1], ~mis};
    endfunction

    // Strobe one pair; clr raises clear_sticky on the cycle the flags update.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
        @(negedge clk);
        value_a   = a;
        value_b   = b;
        cmp_valid = 1'b1;
        @(negedge clk);
        cmp_valid    = 1'b0;
        clear_sticky = clr;
        @(negedge clk);
        clear_sticky = 1'b0;
        model_compare(a, b, clr);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        for (int k = 0; k < DIGITS; k++) m_sticky[k] = 1'b0;
    endtask

    // Records the segment pattern seen for each enabled digit over a full scan.
    task automatic capture_scan();
        for (int k = 0; k < DIGITS; k++) obs_hit[k] = 1'b0;
        obs_bad = 0;
        repeat (DIV * DIGITS + DIV) begin
            int zeros;
            @(negedge clk);
            zeros = 0;
            for (int k = 0; k < DIGITS; k++) begin
                if (an_out[k] === 1'b0) begin
                    zeros++;
                    obs_seg[k] = seg_out;
                    obs_hit[k] = 1'b1;
                end
            end
            if (zeros != 1) obs_bad++;
        end
    endtask

    task automatic test_reset();
        logic [DIGITS-1:0] exp_an;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (seg_out !== 8'hFF) $display("FAIL reset_seg: got %h exp ff", seg_out); else n_pass++;
        n_checks++; if (an_out !== '1) $display("FAIL reset_an: got %b exp 1111", an_out); else n_pass++;
        n_checks++; if (match_all !== 1'b0) $display("FAIL reset_match: got %b exp 0", match_all); else n_pass++;
        n_checks++; if (mismatch_seen !== 1'b0) $display("FAIL reset_seen: got %b exp 0", mismatch_seen); else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * DIV * DIGITS; i++) begin
            @(negedge clk);
            exp_an = '1;
            exp_an[(i / DIV) % DIGITS] = 1'b0;
            n_checks++; if (an_out !== exp_an) $display("FAIL walk_an[%0d]: got %b exp %b", i, an_out, exp_an); else n_pass++;
            n_checks++; if (seg_out !== 8'hFF) $display("FAIL walk_blank[%0d]: got %h exp ff", i, seg_out); else n_pass++;
        end
    endtask

    task automatic test_mode0();
        mode = 1'b0;
        sticky_en = 1'b0;
        do_cmp(16'h12A4, 16'h12B4, 1'b0);
        n_checks++; if (match_all !== m_match) $display("FAIL mode0_match: got %b exp %b", match_all, m_match); else n_pass++;
        capture_scan();
        n_checks++; if (obs_bad !== 0) $display("FAIL mode0_an_onehot: got %0d bad exp 0", obs_bad); else n_pass++;
        for (int k = 0; k < DIGITS; k++) begin
            n_checks++;
            if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL mode0_seg[%0d]: got %h exp %h", k, obs_seg[k], exp_seg(k));
            else n_pass++;
        end
    endtask

    task automatic test_mode1();
        mode = 1'b1;
        capture_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_checks++;
            if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL mode1_seg[%0d]: got %h exp %h", k, obs_seg[k], exp_seg(k));
            else n_pass++;
        end
    endtask

    task automatic test_sticky();
        mode = 1'b0;
        sticky_en = 1'b1;
        do_cmp(16'h5555, 16'h5555, 1'b0);
        n_checks++; if (match_all !== 1'b1) $display("FAIL sticky_match: got %b exp 1", match_all); else n_pass++;
        n_checks++; if (mismatch_seen !== model_mis_seen()) $display("FAIL sticky_seen: got %b exp %b", mismatch_seen, model_mis_seen()); else n_pass++;
        capture_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_checks++;
            if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL sticky_seg[%0d]: got %h exp %h", k, obs_seg[k], exp_seg(k));
            else n_pass++;
        end
        pulse_clear();
        n_checks++; if (mismatch_seen !== 1'b0) $display("FAIL cleared_seen: got %b exp 0", mismatch_seen); else n_pass++;
        capture_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_checks++;
            if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL cleared_seg[%0d]: got %h exp %h", k, obs_seg[k], exp_seg(k));
            else n_pass++;
        end
    endtask

    task automatic test_clear_collision();
        mode = 1'b0;
        sticky_en = 1'b1;
        do_cmp(16'h0001, 16'h0000, 1'b0);
        do_cmp(16'h0300, 16'h0000, 1'b1);
        n_checks++; if (mismatch_seen !== 1'b1) $display("FAIL collide_seen: got %b exp 1", mismatch_seen); else n_pass++;
        capture_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_checks++;
            if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL collide_seg[%0d]: got %h exp %h", k, obs_seg[k], exp_seg(k));
            else n_pass++;
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        for (int i = 0; i < 3; i++) begin
            pa[i] = W'($urandom);
            pb[i] = (i == 1) ? pa[i] : pa[i] ^ W'(16'h0100);
        end
        @(negedge clk);
        value_a = pa[0]; value_b = pb[0]; cmp_valid = 1'b1;
        @(negedge clk);
        value_a = pa[1]; value_b = pb[1];
        @(negedge clk);
        value_a = pa[2]; value_b = pb[2];
        model_compare(pa[0], pb[0], 1'b0);
        n_checks++; if (match_all !== m_match) $display("FAIL b2b_match0: got %b exp %b", match_all, m_match); else n_pass++;
        @(negedge clk);
        cmp_valid = 1'b0;
        model_compare(pa[1], pb[1], 1'b0);
        n_checks++; if (match_all !== m_match) $display("FAIL b2b_match1: got %b exp %b", match_all, m_match); else n_pass++;
        @(negedge clk);
        model_compare(pa[2], pb[2], 1'b0);
        n_checks++; if (match_all !== m_match) $display("FAIL b2b_match2: got %b exp %b", match_all, m_match); else n_pass++;
        pulse_clear();

        // Mismatch then match back to back, reset lands on the second update.
        @(negedge clk);
        value_a = 16'h1234; value_b = 16'h1334; cmp_valid = 1'b1;
        @(negedge clk);
        value_a = 16'h5555; value_b = 16'h5555;
        @(negedge clk);
        cmp_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_checks++; if (seg_out !== 8'hFF) $display("FAIL b2b_rst_seg: got %h exp ff", seg_out); else n_pass++;
        n_checks++; if (an_out !== '1) $display("FAIL b2b_rst_an: got %b exp 1111", an_out); else n_pass++;
        n_checks++; if (match_all !== 1'b0) $display("FAIL b2b_rst_match: got %b exp 0", match_all); else n_pass++;
        n_checks++; if (mismatch_seen !== 1'b0) $display("FAIL b2b_rst_seen: got %b exp 0", mismatch_seen); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (mismatch_seen !== 1'b0 || match_all !== 1'b0 || seg_out !== 8'hFF)
                $display("FAIL b2b_post_rst[%0d]: got seen=%b match=%b seg=%h exp 0 0 ff", i, mismatch_seen, match_all, seg_out);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        bit clr;
        for (int it = 0; it < 16; it++) begin
            mode      = 1'($urandom_range(0, 1));
            sticky_en = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = a;
            for (int k = 0; k < DIGITS; k++)
                if ($urandom_range(0, 2) == 0) b[4*k +: 4] = 4'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            do_cmp(a, b, clr);
            n_checks++; if (match_all !== m_match) $display("FAIL rnd_match[%0d]: got %b exp %b", it, match_all, m_match); else n_pass++;
            n_checks++; if (mismatch_seen !== model_mis_seen()) $display("FAIL rnd_seen[%0d]: got %b exp %b", it, mismatch_seen, model_mis_seen()); else n_pass++;
            capture_scan();
            n_checks++; if (obs_bad !== 0) $display("FAIL rnd_an_onehot[%0d]: got %0d bad exp 0", it, obs_bad); else n_pass++;
            for (int k = 0; k < DIGITS; k++) begin
                n_checks++;
                if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL rnd_seg[%0d][%0d]: got %h exp %h", it, k, obs_seg[k], exp_seg(k));
                else n_pass++;
            end
            mode      = ~mode;
            sticky_en = 1'($urandom_range(0, 1));
            capture_scan();
            n_checks++; if (mismatch_seen !== model_mis_seen()) $display("FAIL rnd_seen_hold[%0d]: got %b exp %b", it, mismatch_seen, model_mis_seen()); else n_pass++;
            for (int k = 0; k < DIGITS; k++) begin
                n_checks++;
                if (!obs_hit[k] || obs_seg[k] !== exp_seg(k)) $display("FAIL rnd_toggle_seg[%0d][%0d]: got %h exp %h", it, k, obs_seg[k], exp_seg(k));
                else n_pass++;
            end
            if ($urandom_range(0, 3) == 0) pulse_clear();
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_sticky();
        test_clear_collision();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_compare_scan.md
SEVEN_SEG_COMPARE_SCAN -- requirements
Module: seven_seg_compare_scan

Interface
REQ-001 Parameter DIGITS, default 8: number of 4-bit digit positions compared and displayed; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles each digit is driven; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 value_a  input  4*DIGITS  measured value, digit k = bits [4k+3:4k].
REQ-006 value_b  input  4*DIGITS  expected value, same digit packing.
REQ-007 cmp_valid  input  1  one-cycle strobe; samples value_a and value_b.
REQ-008 mode  input  1  0 = U/L per digit; 1 = hex of value_a with dp lit on mismatching digits.
REQ-009 sticky_en  input  1  1 = a digit mismatch is held until clear_sticky.
REQ-010 clear_sticky  input  1  one-cycle strobe; clears all sticky mismatch flags.
REQ-011 seg_out  output  8  segments, active-low, bit7..bit1 = a..g, bit0 = dp.
REQ-012 an_out  output  DIGITS  digit enables, active-low, exactly one low after first refresh tick.
REQ-013 match_all  output  1  1 when every digit of the last sampled pair matches.
REQ-014 mismatch_seen  output  1  OR of all sticky mismatch flags.

Function
REQ-015 On cmp_valid = 1 the block SHALL register value_a and value_b (cycle t+1) and register per-digit equal flags, match_all and sticky updates at cycle t+2.
REQ-016 cmp_valid asserted on consecutive cycles SHALL be accepted every cycle, pipelined, no stall.
REQ-017 A digit's displayed state SHALL be "mismatch" if its current equal flag is 0, or if sticky_en = 1 and its sticky flag is 1.
REQ-018 Mode 0: match digit SHALL show U (8'b10000011), mismatch digit SHALL show L (8'b11100011).
REQ-019 Mode 1: digit SHALL show the hex glyph of the sampled value_a nibble (0-9, A-F), with dp (bit0) driven 0 when mismatch, 1 when match.
REQ-020 Before the first accepted cmp_valid after reset, every digit SHALL show blank (8'hFF) in both modes.
REQ-021 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-022 seg_out and an_out SHALL be registered and change one cycle after the digit index changes; an_out SHALL enable only the indexed digit.
REQ-023 Sticky flag k SHALL be set at the t+2 update when digit k mismatches, independent of sticky_en; cleared by clear_sticky.
REQ-024 clear_sticky coinciding with a sticky set for the same digit SHALL leave the flag set (new mismatch wins).
REQ-025 mode and sticky_en changes SHALL take effect at the next seg_out register update without affecting stored flags.
REQ-026 A DIGITS = 1 instance SHALL hold the index at 0 and keep an_out low after the first refresh tick.

Reset
REQ-027 While rst_n = 0 at a clk edge: seg_out = 8'hFF, an_out = all ones, match_all = 0, mismatch_seen = 0, counter and index = 0, equal flags = all 1, sticky flags = 0, sampled registers = 0, valid-seen = 0.
REQ-028 Reset asserted mid-pipeline SHALL discard in-flight samples; no flag update SHALL occur from a cmp_valid within two cycles before reset.

Structure
REQ-029 Shared package SHALL hold segment constants SEG_U, SEG_L, SEG_BLANK and the 16 hex glyph constants.
REQ-030 One sub-module, hex_to_seg (4-bit in, 8-bit active-low out, combinational), SHALL implement the glyph table.
REQ-031 Equal compare, sticky logic, refresh counter and output mux SHALL reside in seven_seg_compare_scan.

Verification (DIGITS = 4, REFRESH_DIV = 4)
REQ-032 Reset, no cmp_valid -> seg_out = 8'hFF always; an_out walks 1110,1101,1011,0111 every 4 cycles, wraps.
REQ-033 mode 0, cmp_valid with a = 16'h12A4, b = 16'h12B4 -> at t+2 match_all = 0; digit 1 shows 8'b11100011, digits 0,2,3 show 8'b10000011.
REQ-034 mode 1, same values -> digit 1 shows A glyph with bit0 = 0; others show 4,2,1 glyphs with bit0 = 1.
REQ-035 sticky_en = 1, mismatch then matching pair 16'h5555/16'h5555 -> match_all = 1, mismatch_seen = 1, digit 1 still L; clear_sticky -> all U.
REQ-036 clear_sticky in the same cycle as a mismatching t+2 update on digit 2 -> flag 2 remains 1, mismatch_seen = 1.
REQ-037 Back-to-back cmp_valid (mismatch then match) then rst_n low one cycle -> all outputs at reset values, no sticky flag set.
